// File: rtl/program_counter_pkg.sv
// rtl/program_counter_pkg.sv - shared CPU fetch-stage constants and next-address op decode
//
// Purpose: address width, reset vector and step shared by the program counter
//          and its next-address selector, plus the branch/increment priority decode.
// Ports:   none (package).
`timescale 1ns/1ps
package program_counter_pkg;

   localparam int                    ADDR_WIDTH      = 16;
   localparam logic [ADDR_WIDTH-1:0] PC_RESET_VECTOR = 16'h0000;
   localparam int                    PC_STEP         = 1;

   typedef enum logic [1:0] {
      PC_HOLD   = 2'b00,
      PC_INC    = 2'b01,
      PC_BRANCH = 2'b10
   } pc_op_e;

   // Branch wins over increment, so a branch is taken even with increment low.
   function automatic pc_op_e pc_decode(input logic branch, input logic increment);
      if (branch) begin
         return PC_BRANCH;
      end
      if (increment) begin
         return PC_INC;
      end
      return PC_HOLD;
   endfunction

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - combinational next-address mux and adder for the program counter
//
// Purpose: picks the next fetch address from branch target, address + STEP, or hold.
// Ports:
//   address      in  WIDTH  current program counter value
//   bra_add      in  WIDTH  branch target, loaded verbatim
//   branch       in  1      select bra_add (highest priority)
//   increment    in  1      select address + STEP when branch is low
//   next_address out WIDTH  value the register loads on the next edge
`timescale 1ns/1ps
module pc_next_sel
   import program_counter_pkg::*;
#(
   parameter int WIDTH = ADDR_WIDTH,
   parameter int STEP  = PC_STEP
) (
   input  logic [WIDTH-1:0] address,
   input  logic [WIDTH-1:0] bra_add,
   input  logic             branch,
   input  logic             increment,
   output logic [WIDTH-1:0] next_address
);

   pc_op_e op;

   always_comb begin
      op           = pc_decode(branch, increment);
      next_address = address;
      case (op)
         PC_BRANCH: next_address = bra_add;
         // Natural WIDTH-bit overflow gives the wrap from all-ones to zero.
         PC_INC:    next_address = address + WIDTH'(STEP);
         default:   next_address = address;
      endcase
   end

endmodule

// File: rtl/program_counter.sv
// rtl/program_counter.sv - fetch-stage program counter register
//
// Purpose: holds the instruction fetch address; branch, increment or hold each edge.
// Ports:
//   clk       in  1      system clock, rising edge
//   rst       in  1      asynchronous active-high reset to RESET_VECTOR
//   branch    in  1      load bra_add on the next edge
//   increment in  1      advance by STEP when branch is low
//   bra_add   in  WIDTH  branch target address
//   address   out WIDTH  registered program counter value
`timescale 1ns/1ps
module program_counter
   import program_counter_pkg::*;
#(
   parameter int               WIDTH        = ADDR_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR),
   parameter int               STEP         = PC_STEP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             branch,
   input  logic             increment,
   input  logic [WIDTH-1:0] bra_add,
   output logic [WIDTH-1:0] address
);

   logic [WIDTH-1:0] next_address;

   pc_next_sel #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
   ) u_next_sel (
      .address      (address),
      .bra_add      (bra_add),
      .branch       (branch),
      .increment    (increment),
      .next_address (next_address)
   );

   // The register drives address directly; no input reaches it combinationally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         address <= RESET_VECTOR;
      end else begin
         address <= next_address;
      end
   end

endmodule

// File: tb/tb_program_counter.sv
// tb/tb_program_counter.sv - scoreboard bench for program_counter
`timescale 1ns/1ps
module tb_program_counter;

   localparam logic [15:0] RV = 16'h0000;

   typedef struct {
      logic [15:0] addr;
      string       tag;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        branch = 1'b0;
   logic        increment = 1'b0;
   logic [15:0] bra_add = 16'h0000;
   logic [15:0] address;

   int   vectors = 0;
   int   miscompares = 0;
   int   model_pc = 0;
   exp_t exp_q[$];

   program_counter #(
      .WIDTH        (16),
      .RESET_VECTOR (RV),
      .STEP         (1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .branch    (branch),
      .increment (increment),
      .bra_add   (bra_add),
      .address   (address)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: address=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs between edges and queue the address the next edge must give.
   task automatic step(input string tag, input logic r, input logic br, input logic inc,
                       input logic [15:0] ba);
      exp_t e;
      @(negedge clk);
      rst       = r;
      branch    = br;
      increment = inc;
      bra_add   = ba;
      if (r)        model_pc = int'(RV);
      else if (br)  model_pc = int'(ba);
      else if (inc) model_pc = (model_pc + 1) % 65536;
      e.addr = 16'(model_pc);
      e.tag  = tag;
      exp_q.push_back(e);
   endtask

   // Raise rst between edges; address must already be the reset vector before the next edge.
   task automatic async_reset(input string tag);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check(tag, address, RV);
      model_pc = int'(RV);
   endtask

   // Monitor: every edge with a queued expectation is checked just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.tag, address, e.addr);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic        r_r;
      logic        r_br;
      logic        r_inc;
      logic [15:0] r_ba;

      // 1. async reset on rise, then two edges with increment high under reset
      increment = 1'b1;
      #3;
      rst = 1'b1;
      #1;
      check("reset_immediate", address, RV);
      model_pc = int'(RV);
      step("reset_hold", 1'b1, 1'b0, 1'b1, 16'h0000);
      step("reset_hold", 1'b1, 1'b0, 1'b1, 16'h0000);

      // 2. increments 1..4, then on to 6
      for (int i = 0; i < 6; i++) step("increment", 1'b0, 1'b0, 1'b1, 16'h0000);

      // 3. branch held two edges, then increments from the target
      step("branch_k1", 1'b0, 1'b1, 1'b1, 16'h3524);
      step("branch_k2", 1'b0, 1'b1, 1'b1, 16'h3524);
      step("after_branch", 1'b0, 1'b0, 1'b1, 16'h0000);
      step("after_branch", 1'b0, 1'b0, 1'b1, 16'h0000);

      // 4. hold
      for (int i = 0; i < 5; i++) step("hold", 1'b0, 1'b0, 1'b0, 16'hABCD);

      // 5. branch without increment
      step("branch_no_inc", 1'b0, 1'b1, 1'b0, 16'h0100);

      // 6. wrap, then async reset between edges
      step("branch_ffff", 1'b0, 1'b1, 1'b0, 16'hFFFF);
      step("wrap", 1'b0, 1'b0, 1'b1, 16'h0000);
      step("post_wrap", 1'b0, 1'b0, 1'b1, 16'h0000);
      step("pre_async", 1'b0, 1'b0, 1'b1, 16'h0000);
      async_reset("async_mid_cycle");
      step("release_inc", 1'b0, 1'b0, 1'b1, 16'h0000);

      // Randomized traffic with occasional synchronous-looking and mid-cycle resets
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 49) == 0) begin
            async_reset("rand_async");
         end else begin
            r_r   = ($urandom_range(0, 29) == 0);
            r_br  = ($urandom_range(0, 3) == 0);
            r_inc = 1'($urandom_range(0, 1));
            r_ba  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            step("random", r_r, r_br, r_inc, r_ba);
         end
      end

      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: pending=%0d expected=0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
